// File: rtl/gray_decode_scheduler_pkg.sv
// Shared definitions for the Gray decode scheduler: FSM encodings and width helper.
package gray_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gray_decode_scheduler_if.sv
// Requester/consumer bundle of the Gray decode scheduler; slave is the scheduler side.
interface gray_decode_scheduler_if
  import gray_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = id_width(N_REQ)
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] gray_in;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       bin_out;
  logic                   bin_valid;
  logic [ID_W-1:0]        bin_id;
  logic                   out_ready;
  logic                   busy;

  modport slave (
    input  req, gray_in, out_ready,
    output ack, bin_out, bin_valid, bin_id, busy
  );

  modport master (
    output req, gray_in, out_ready,
    input  ack, bin_out, bin_valid, bin_id, busy
  );

endinterface

// File: rtl/gray_decode_scheduler_arbiter.sv
// Combinational round-robin pick: first set req after index 'last', wrapping to 0.
module gray_rr_arbiter
  import gray_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any_req
);

  int              cand;
  logic [ID_W-1:0] sel;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    cand    = 0;
    sel     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last) + k) % N_REQ;
      sel  = ID_W'(cand);
      if (!any_req && req[sel]) begin
        any_req     = 1'b1;
        grant[sel]  = 1'b1;
        gnt_idx     = sel;
      end
    end
  end

endmodule

// File: rtl/gray_decode_scheduler.sv
// One bit-serial Gray-to-binary engine shared round-robin among N_REQ requesters.
// Decodes MSB-first, one bit per cycle; result held on valid/ready until accepted.
module gray_decode_scheduler
  import gray_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  gray_decode_scheduler_if.slave bus
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = id_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] bin_out_q, bin_out_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  bin_id_q, bin_id_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic             bin_valid_q, bin_valid_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [N_REQ-1:0] gnt_oh;
  logic [ID_W-1:0]  gnt_idx;
  logic             any_req;
  logic [WIDTH-1:0] gray_sel;
  logic             bit_v;

  gray_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req),
    .last    (last_q),
    .grant   (gnt_oh),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  always_comb begin
    gray_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) gray_sel = bus.gray_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    gray_d      = gray_q;
    bin_d       = bin_q;
    bin_out_d   = bin_out_q;
    id_d        = id_q;
    bin_id_d    = bin_id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    bin_valid_d = bin_valid_q;
    ack_d       = '0;
    bit_v       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gray_d  = gray_sel;
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          ack_d   = gnt_oh;
          cnt_d   = CNT_W'(WIDTH - 1);
          prev_d  = 1'b0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        bit_v        = prev_q ^ gray_q[cnt_q];
        bin_d[cnt_q] = bit_v;
        prev_d       = bit_v;
        // Exit is tested before decrementing so cnt never wraps.
        if (cnt_q == '0) begin
          bin_out_d   = bin_d;
          bin_id_d    = id_q;
          bin_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          bin_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gray_q      <= '0;
      bin_q       <= '0;
      bin_out_q   <= '0;
      id_q        <= '0;
      bin_id_q    <= '0;
      last_q      <= ID_W'(N_REQ - 1);
      cnt_q       <= '0;
      prev_q      <= 1'b0;
      bin_valid_q <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      gray_q      <= gray_d;
      bin_q       <= bin_d;
      bin_out_q   <= bin_out_d;
      id_q        <= id_d;
      bin_id_q    <= bin_id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      bin_valid_q <= bin_valid_d;
      ack_q       <= ack_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.bin_out   = bin_out_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.bin_id    = bin_id_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gray_decode_scheduler.sv
// Directed bench for gray_decode_scheduler (N_REQ=4, WIDTH=4); outputs sampled on falling edges.
module tb_gray_decode_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gray_decode_scheduler_if #(.N_REQ(4), .WIDTH(4)) bus ();

  gray_decode_scheduler #(.N_REQ(4), .WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (bus.bin_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
  endtask

  task automatic run_one(input logic [3:0] rq, input logic [15:0] gi, input logic [3:0] exp_ack,
                         input logic [3:0] exp_bin, input logic [1:0] exp_id, input string tag);
    @(negedge clk);
    bus.req       = rq;
    bus.gray_in   = gi;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ack"}, bus.ack, exp_ack);
    chk({tag, "_busy"}, bus.busy, 1);
    bus.req = '0;
    wait_valid(tag, 4);
    chk({tag, "_bin"}, bus.bin_out, exp_bin);
    chk({tag, "_id"}, bus.bin_id, exp_id);
    @(negedge clk);
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_vld_low"}, bus.bin_valid, 0);
    chk({tag, "_hold"}, bus.bin_out, exp_bin);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", bus.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rr_exp [4];
    logic [3:0] hold_bin;
    logic [1:0] hold_id;
    int ng, nv, last_cyc;

    rr_exp[0] = 4'b0100;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0110;
    rr_exp[3] = 4'b1010;

    rst_n = 1'b0;
    bus.req = '0;
    bus.gray_in = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_bin", bus.bin_out, 0);
    chk("rst_vld", bus.bin_valid, 0);
    chk("rst_id", bus.bin_id, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_ack", bus.ack, 0);

    run_one(4'b0001, 16'h000D, 4'b0001, 4'b1001, 2'd0, "single");
    run_one(4'b0100, 16'h0800, 4'b0100, 4'b1111, 2'd2, "ones");
    run_one(4'b0100, 16'h0000, 4'b0100, 4'b0000, 2'd2, "zero");

    // Fresh reset so round robin starts at requester 0.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    bus.gray_in = 16'hF536;
    bus.out_ready = 1'b1;
    ng = 0;
    nv = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (bus.ack != 4'b0000) begin
        chk("rr_ack", bus.ack, 32'(1 << (ng % 4)));
        if (ng > 0) chk("rr_period", cyc - last_cyc, 6);
        last_cyc = cyc;
        ng++;
      end
      if (bus.bin_valid) begin
        chk("rr_id", bus.bin_id, nv % 4);
        chk("rr_bin", bus.bin_out, rr_exp[nv % 4]);
        nv++;
      end
    end
    bus.req = '0;
    chk("rr_grants", ng, 5);
    chk("rr_results", nv, 5);
    drain();

    // Backpressure: requester 0 served, requester 1 waits behind held result.
    @(negedge clk);
    bus.req = 4'b0001;
    bus.gray_in = 16'h00A7;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ack0", bus.ack, 4'b0001);
    bus.req = 4'b0010;
    wait_valid("bp0", 4);
    chk("bp_bin0", bus.bin_out, 4'b0101);
    chk("bp_id0", bus.bin_id, 0);
    hold_bin = bus.bin_out;
    hold_id = bus.bin_id;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_vld_hold", bus.bin_valid, 1);
      chk("bp_bin_hold", bus.bin_out, hold_bin);
      chk("bp_id_hold", bus.bin_id, hold_id);
      chk("bp_no_ack", bus.ack, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_vld_fall", bus.bin_valid, 0);
    chk("bp_ack_gap", bus.ack, 0);
    chk("bp_idle", bus.busy, 0);
    @(negedge clk);
    chk("bp_ack1", bus.ack, 4'b0010);
    bus.req = '0;
    wait_valid("bp1", 4);
    chk("bp_bin1", bus.bin_out, 4'b1100);
    chk("bp_id1", bus.bin_id, 1);
    @(negedge clk);
    drain();

    // Reset in cycle 3 of a conversion owned by requester 1.
    @(negedge clk);
    bus.req = 4'b0010;
    bus.gray_in = 16'h00A7;
    @(negedge clk);
    chk("mr_ack", bus.ack, 4'b0010);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_bin", bus.bin_out, 0);
    chk("mr_vld", bus.bin_valid, 0);
    chk("mr_id", bus.bin_id, 0);
    chk("mr_ack0", bus.ack, 0);
    bus.req = 4'b1010;
    @(negedge clk);
    chk("mr_vld_in_rst", bus.bin_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_first_grant", bus.ack, 4'b0010);
    bus.req = '0;
    wait_valid("mr", 4);
    chk("mr_bin_after", bus.bin_out, 4'b1100);
    chk("mr_id_after", bus.bin_id, 1);
    @(negedge clk);
    drain();

    for (int g = 0; g < 16; g++) begin
      logic [3:0] gv;
      gv = 4'(g);
      run_one(4'b1000, {gv, 12'h000}, 4'b1000, g2b(gv), 2'd3, "exh");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
